// File: rtl/retospect_cfg_loader.sv
// Byte-fed loader for a serial configuration chain: shifts CHAIN_LEN bits out
// LSB first while capturing the chain tail into readback bytes.
module retospect_cfg_loader #(
  parameter int CHAIN_LEN = 498,
  parameter int CNT_W     = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       cfg_en,
  output logic       cfg_bs,
  input  logic       cfg_ret,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] bits_sent_q, bits_sent_d;
  logic [3:0]       rb_idx_q, rb_idx_d;
  logic [7:0]       rb_acc_q, rb_acc_d;
  logic [7:0]       rb_data_q, rb_data_d;
  logic             rb_valid_q, rb_valid_d;
  logic             cfg_en_q, cfg_en_d;
  logic             cfg_bs_q, cfg_bs_d;
  logic             byte_ready_q, byte_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             last_bit;
  logic [7:0]       acc_next;

  // A byte ends after its 8th bit or when the chain is full, whichever is first;
  // that also truncates the final byte so its unused upper bits never shift out.
  assign last_bit = (rb_idx_q == 4'd7) || (bits_sent_q == LAST_BIT);
  assign acc_next = rb_acc_q | (8'(cfg_ret) << rb_idx_q[2:0]);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bits_sent_d = bits_sent_q;
    rb_idx_d    = rb_idx_q;
    rb_acc_d    = rb_acc_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          bits_sent_d = '0;
          rb_idx_d    = '0;
          rb_acc_d    = '0;
        end
      end
      LOAD: begin
        if (byte_valid) begin
          shift_d = byte_data;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d     = shift_q >> 1;
        bits_sent_d = bits_sent_q + CNT_W'(1);
        if (last_bit) begin
          rb_data_d  = acc_next;
          rb_valid_d = 1'b1;
          rb_idx_d   = '0;
          rb_acc_d   = '0;
          state_d    = (bits_sent_q == LAST_BIT) ? FIN : LOAD;
        end else begin
          rb_idx_d = rb_idx_q + 4'd1;
          rb_acc_d = acc_next;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe.
    cfg_en_d     = (state_d == SHIFT);
    cfg_bs_d     = shift_d[0];
    byte_ready_d = (state_d == LOAD);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bits_sent_q  <= '0;
      rb_idx_q     <= '0;
      rb_acc_q     <= '0;
      rb_data_q    <= '0;
      rb_valid_q   <= 1'b0;
      cfg_en_q     <= 1'b0;
      cfg_bs_q     <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bits_sent_q  <= bits_sent_d;
      rb_idx_q     <= rb_idx_d;
      rb_acc_q     <= rb_acc_d;
      rb_data_q    <= rb_data_d;
      rb_valid_q   <= rb_valid_d;
      cfg_en_q     <= cfg_en_d;
      cfg_bs_q     <= cfg_bs_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign cfg_en     = cfg_en_q;
  assign cfg_bs     = cfg_bs_q;
  assign rb_data    = rb_data_q;
  assign rb_valid   = rb_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Bench for retospect_cfg_loader: a 10-bit chain instance with a chain model,
// plus a default-length instance with its tail tied high.
module tb_retospect_cfg_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready, cfg_en, cfg_bs, cfg_ret, rb_valid, busy, done;
  logic [7:0] rb_data;

  logic       start2, byte_valid2;
  logic [7:0] byte_data2;
  logic       byte_ready2, cfg_en2, cfg_bs2, rb_valid2, busy2, done2;
  logic [7:0] rb_data2;

  logic [9:0] chain = '0;

  int vec  = 0;
  int errs = 0;
  int en_cnt = 0, done_cnt = 0;
  int en2_cnt = 0, rb2_cnt = 0, done2_cnt = 0;

  logic       exp_bs[$];
  logic [7:0] exp_rb[$];
  logic       exp_bs2[$];
  logic       bs_e, bs2_e;
  logic [7:0] rb_e, rb2_e;

  always #5 clk = ~clk;

  retospect_cfg_loader #(.CHAIN_LEN(10), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .cfg_en(cfg_en),
    .cfg_bs(cfg_bs), .cfg_ret(cfg_ret), .rb_data(rb_data),
    .rb_valid(rb_valid), .busy(busy), .done(done)
  );

  retospect_cfg_loader u_big (
    .clk(clk), .reset(reset), .start(start2), .byte_data(byte_data2),
    .byte_valid(byte_valid2), .byte_ready(byte_ready2), .cfg_en(cfg_en2),
    .cfg_bs(cfg_bs2), .cfg_ret(1'b1), .rb_data(rb_data2),
    .rb_valid(rb_valid2), .busy(busy2), .done(done2)
  );

  // 10-bit chain: bs_in enters at bit 9, bs_out is bit 0.
  assign cfg_ret = chain[0];
  always @(posedge clk) if (cfg_en) chain <= {cfg_bs, chain[9:1]};

  always @(negedge clk) begin
    if (!reset) begin
      if (cfg_en) begin
        en_cnt++;
        vec++;
        if (exp_bs.size() == 0) begin
          errs++;
          $error("FAIL bs_extra: observed shift with cfg_bs=%0b, expected none", cfg_bs);
        end else begin
          bs_e = exp_bs.pop_front();
          assert (cfg_bs === bs_e) else begin
            errs++;
            $error("FAIL cfg_bs: observed %0b expected %0b", cfg_bs, bs_e);
          end
        end
      end
      if (rb_valid) begin
        vec++;
        if (exp_rb.size() == 0) begin
          errs++;
          $error("FAIL rb_extra: observed %02h expected no strobe", rb_data);
        end else begin
          rb_e = exp_rb.pop_front();
          assert (rb_data === rb_e) else begin
            errs++;
            $error("FAIL rb_data: observed %02h expected %02h", rb_data, rb_e);
          end
        end
      end
      if (done) done_cnt++;
      if (cfg_en2) begin
        en2_cnt++;
        vec++;
        bs2_e = (exp_bs2.size() != 0) ? exp_bs2.pop_front() : 1'bx;
        assert (cfg_bs2 === bs2_e) else begin
          errs++;
          $error("FAIL big_cfg_bs: observed %0b expected %0b", cfg_bs2, bs2_e);
        end
      end
      if (rb_valid2) begin
        rb2_cnt++;
        vec++;
        rb2_e = (rb2_cnt == 63) ? 8'h03 : 8'hFF;
        assert (rb_data2 === rb2_e) else begin
          errs++;
          $error("FAIL big_rb_data: observed %02h expected %02h", rb_data2, rb2_e);
        end
      end
      if (done2) done2_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vec++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) exp_bs.push_back(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("byte_ready_timeout", 16'(byte_ready), 16'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 16'(busy), 16'd0);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] r0, input logic [7:0] r1,
                          input bit stall, input bit start_mid);
    int n = 0;
    en_cnt = 0;
    done_cnt = 0;
    push_bits(b0, 8);
    push_bits(b1, 2);
    exp_rb.push_back(r0);
    exp_rb.push_back(r1);
    pulse_start();
    chk("busy_after_start", 16'(busy), 16'd1);
    send_byte(b0);
    if (start_mid) pulse_start();
    if (stall) begin
      byte_valid = 1'b0;
      while (!byte_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      repeat (5) begin
        @(negedge clk);
        chk("stall_cfg_en", 16'(cfg_en), 16'd0);
      end
      chk("stall_bits_held", 16'(en_cnt), 16'd8);
    end
    send_byte(b1);
    byte_valid = 1'b0;
    wait_idle();
    chk("en_cycles", 16'(en_cnt), 16'd10);
    chk("done_count", 16'(done_cnt), 16'd1);
    chk("rb_pending", 16'(exp_rb.size()), 16'd0);
    chk("idle_byte_ready", 16'(byte_ready), 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; byte_valid = 1'b0; byte_data = '0;
    start2 = 1'b0; byte_valid2 = 1'b0; byte_data2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {busy, done, cfg_en, cfg_bs, byte_ready, rb_valid, rb_data}, 16'h0);
    chk("rst_big_outputs", {busy2, done2, cfg_en2, cfg_bs2, byte_ready2, rb_valid2, rb_data2}, 16'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic load into an all-zero chain, then reload to read the first load back.
    run_load(8'hA5, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
    run_load(8'hA5, 8'h03, 8'hA5, 8'h03, 1'b0, 1'b0);
    // Backpressure between bytes.
    run_load(8'hA5, 8'h03, 8'hA5, 8'h03, 1'b1, 1'b0);
    // Start pulse while shifting.
    run_load(8'hA5, 8'h03, 8'hA5, 8'h03, 1'b0, 1'b1);

    // Reset after four chain shifts.
    en_cnt = 0;
    push_bits(8'hA5, 8);
    pulse_start();
    send_byte(8'hA5);
    byte_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_outputs", {busy, done, cfg_en, cfg_bs, byte_ready, rb_valid, rb_data}, 16'h0);
    exp_bs.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_shift_count", 16'(en_cnt), 16'd4);
    chk("midrst_stays_idle", 16'(busy), 16'd0);
    // Chain now holds 0,1,0,1,1,1,1,0,1,0 from tail to head.
    run_load(8'h5A, 8'h01, 8'h7A, 8'h01, 1'b0, 1'b0);

    // Default-length chain: 63 bytes, the last one only two bits wide.
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int i = 0; i < 63; i++) begin
      logic [7:0] b;
      int n;
      b = 8'(i * 37 + 5);
      for (int k = 0; k < ((i == 62) ? 2 : 8); k++) exp_bs2.push_back(b[k]);
      byte_data2 = b;
      byte_valid2 = 1'b1;
      n = 0;
      while (!byte_ready2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!byte_ready2) chk("big_ready_timeout", 16'(byte_ready2), 16'd1);
      @(posedge clk);
      #1;
    end
    byte_valid2 = 1'b0;
    begin
      int n = 0;
      while (busy2 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    chk("big_busy", 16'(busy2), 16'd0);
    chk("big_en_cycles", 16'(en2_cnt), 16'd498);
    chk("big_rb_strobes", 16'(rb2_cnt), 16'd63);
    chk("big_done", 16'(done2_cnt), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
